// File: rtl/score_ram_arbiter.sv
// -----------------------------------------------------------------------------
// score_ram_arbiter
//
// Shares the single-port score RAM between the game-over score writer, the
// score-view reader and a clear-all request. Each access is a level
// request / one-cycle completion pulse handshake. The block also owns the
// ring-buffer write pointer, the stored-score count and the running high score.
//
// Ports
//   Clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   wr_req       level request to store wr_score
//   wr_score     score to store, sampled at grant
//   wr_ack       one-cycle write completion
//   rd_req       level request to read slot rd_index
//   rd_index     slot to read, sampled at grant
//   rd_valid     one-cycle pulse, rd_data valid
//   rd_data      read result, held until the next read completes
//   clr_req      level request to zero all slots and statistics
//   clr_done     one-cycle clear completion
//   ram_addr     RAM address (RAM registers it, one-cycle read latency)
//   ram_wdata    RAM write data
//   ram_we       RAM write enable
//   ram_rdata    RAM read data, valid the cycle after the address cycle
//   next_slot    next ring-buffer write slot
//   score_count  number of valid slots, saturating at DEPTH
//   high_score   largest score written since reset or last clear
//   busy         arbiter is servicing a transaction
// -----------------------------------------------------------------------------
module score_ram_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 512,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_score,
  output logic                  wr_ack,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_index,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  clr_req,
  output logic                  clr_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH-1:0] next_slot,
  output logic [ADDR_WIDTH:0]   score_count,
  output logic [DATA_WIDTH-1:0] high_score,
  output logic                  busy
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WRITE    = 3'd1;
  localparam logic [2:0] ST_RD_ADDR  = 3'd2;
  localparam logic [2:0] ST_RD_WAIT  = 3'd3;
  localparam logic [2:0] ST_RD_DONE  = 3'd4;
  localparam logic [2:0] ST_CLEAR    = 3'd5;
  localparam logic [2:0] ST_CLR_DONE = 3'd6;

  localparam logic [ADDR_WIDTH:0]   CNT_MAX   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH-1);

  // Count of valid slots stops at DEPTH once the ring starts overwriting.
  function automatic logic [ADDR_WIDTH:0] count_sat_inc(input logic [ADDR_WIDTH:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  // Unsigned strict max: an equal score leaves the high score untouched.
  function automatic logic [DATA_WIDTH-1:0] high_update(
    input logic [DATA_WIDTH-1:0] cur,
    input logic [DATA_WIDTH-1:0] cand
  );
    return (cand > cur) ? cand : cur;
  endfunction

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] wr_score_q;
  logic [ADDR_WIDTH-1:0] rd_index_q;
  logic                  rd_oob;

  // Slots at or beyond the stored count hold stale data and read back as zero.
  assign rd_oob = ({1'b0, rd_index_q} >= score_count);

  // ---- grant / control stage ----
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      clr_cnt     <= '0;
      next_slot   <= '0;
      score_count <= '0;
      high_score  <= '0;
      rd_data     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end else if (wr_req) begin
            state <= ST_WRITE;
          end else if (rd_req) begin
            state <= ST_RD_ADDR;
          end
        end
        ST_WRITE: begin
          next_slot   <= next_slot + ADDR_ONE;
          score_count <= count_sat_inc(score_count);
          high_score  <= high_update(high_score, wr_score_q);
          state       <= ST_IDLE;
        end
        ST_RD_ADDR: state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          rd_data <= rd_oob ? '0 : ram_rdata;
          state   <= ST_RD_DONE;
        end
        ST_RD_DONE: state <= ST_IDLE;
        ST_CLEAR: begin
          if (clr_cnt == ADDR_LAST) begin
            state <= ST_CLR_DONE;
          end else begin
            clr_cnt <= clr_cnt + ADDR_ONE;
          end
        end
        ST_CLR_DONE: begin
          next_slot   <= '0;
          score_count <= '0;
          high_score  <= '0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- request operand capture ----
  // Operands are captured every IDLE cycle; the value held at the grant edge
  // is the one used by the transaction that follows.
  always_ff @(posedge Clock) begin
    if (state == ST_IDLE) begin
      wr_score_q <= wr_score;
      rd_index_q <= rd_index;
    end
  end

  // ---- RAM port and status outputs ----
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    wr_ack    = 1'b0;
    rd_valid  = 1'b0;
    clr_done  = 1'b0;
    case (state)
      ST_WRITE: begin
        ram_we    = 1'b1;
        ram_addr  = next_slot;
        ram_wdata = wr_score_q;
        wr_ack    = 1'b1;
      end
      ST_RD_ADDR:  ram_addr = rd_index_q;
      ST_RD_DONE:  rd_valid = 1'b1;
      ST_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_cnt;
      end
      ST_CLR_DONE: clr_done = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: doc/score_ram_arbiter.md
# score_ram_arbiter

- Arbitrates the single-port score RAM between three requesters:
  - the game-over score writer (scorekeeper),
  - the score-view reader (menu/score screen),
  - a clear-all request.
- Each access is sequenced as a request/acknowledge transaction.
- The block maintains the ring-buffer write pointer, the stored-score count and the running high score.
- It sits between the game FSM/scorekeeper and the score RAM instance in the top level.

## Interface
- `ADDR_WIDTH`, default 9: score RAM address width.
- `DEPTH`, default 512: number of score slots; equals 2^`ADDR_WIDTH`.
- `DATA_WIDTH`, default 32: score width.

- `Clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wr_req` in 1: level request to store `wr_score`.
- `wr_score` in `DATA_WIDTH`: score to store; sampled at grant.
- `wr_ack` out 1: one-cycle write completion.
- `rd_req` in 1: level request to read slot `rd_index`.
- `rd_index` in `ADDR_WIDTH`: slot to read; sampled at grant.
- `rd_valid` out 1: one-cycle pulse, `rd_data` valid.
- `rd_data` out `DATA_WIDTH`: read result; held until the next read completes.
- `clr_req` in 1: level request to zero all slots and statistics.
- `clr_done` out 1: one-cycle clear completion.
- `ram_addr` out `ADDR_WIDTH`: RAM address (RAM registers it internally, one-cycle read latency).
- `ram_wdata` out `DATA_WIDTH`: RAM write data.
- `ram_we` out 1: RAM write enable.
- `ram_rdata` in `DATA_WIDTH`: RAM read data, valid the cycle after the address cycle.
- `next_slot` out `ADDR_WIDTH`: next write slot.
- `score_count` out `ADDR_WIDTH+1`: number of valid slots, saturating at `DEPTH`.
- `high_score` out `DATA_WIDTH`: largest score written since reset or last clear.
- `busy` out 1: FSM not in IDLE.

## Operation
- **States:** IDLE, WRITE, RD_ADDR, RD_WAIT, RD_DONE, CLEAR, CLR_DONE.
- **Arbitration:**
  - Evaluated only in IDLE. Fixed priority: `clr_req` > `wr_req` > `rd_req`.
  - Requests arriving while `busy` wait; none are dropped.
- **Write grant:**
  - Latch `wr_score`, then go to WRITE.
  - WRITE: `ram_we`=1, `ram_addr`=`next_slot`, `ram_wdata`=latched score, `wr_ack`=1, return to IDLE.
  - On exit, `next_slot` increments modulo `DEPTH` (`DEPTH`-1 wraps to 0, overwriting the oldest slot).
  - `score_count` increments unless already `DEPTH`.
  - `high_score` loads the score if strictly greater, unsigned; an equal score leaves it unchanged.
- **Read grant:**
  - Latch `rd_index`, then go to RD_ADDR.
  - RD_ADDR: `ram_addr`=latched index.
  - RD_WAIT: capture `ram_rdata` into `rd_data`, or force 0 if latched index ≥ `score_count`.
  - RD_DONE: `rd_valid`=1, then return to IDLE.
- **Clear grant:**
  - CLEAR steps an internal counter 0..`DEPTH`-1, one slot per cycle, with `ram_we`=1 and `ram_wdata`=0.
  - Then CLR_DONE: `clr_done`=1; `next_slot`, `score_count` and `high_score` zeroed; return to IDLE.
- **RAM outputs outside these states:** `ram_addr` = 0, `ram_we` = 0, `ram_wdata` = 0.
- **Requester rule:**
  - Hold req until the matching ack/valid/done pulse, then deassert on the following edge.
  - A req still high in IDLE after completion is a new transaction.
- **Reset:**
  - Asynchronous and mid-operation allowed. FSM goes to IDLE; all outputs and counters go to 0, including `rd_data` and `high_score`.
  - RAM contents are not cleared. An interrupted clear leaves partial zeros; an interrupted write either occurred or did not, with no partial data.

## Timing
- **Write:** `wr_req` sampled in IDLE at cycle 0; `wr_ack` and `ram_we` in cycle 1; updated `next_slot`, `score_count` and `high_score` visible in cycle 2. Latency 1, throughput 1 write per 2 cycles.
- **Read:** grant at cycle 0; address in cycle 1; data captured end of cycle 2; `rd_valid` in cycle 3; IDLE in cycle 4.
- **Clear:** grant at cycle 0; writes in cycles 1..`DEPTH`; `clr_done` in cycle `DEPTH`+1.
- **`busy`:** high in every non-IDLE cycle.
- **Output reset values:** all outputs 0.

## Test plan
- **Writes and high score:** reset, then write scores 5, 12, 12, 3.
  - Each write gives `wr_ack` one cycle after grant, with `ram_addr` 0, 1, 2, 3 and `ram_we` high.
  - End state: `high_score`=12, `score_count`=4, `next_slot`=4.
- **Read and out of range:** after the writes above, read `rd_index`=1 → `rd_valid` 3 cycles after grant with `rd_data`=12. Read `rd_index`=7 → `rd_data`=0.
- **Simultaneous requests:** assert `clr_req`, `wr_req` and `rd_req` in the same IDLE cycle.
  - Clear completes first, then the write, then the read.
  - After completion, `high_score` equals the written score and `score_count`=1.
- **Wrap:** perform 513 writes of value `i`.
  - `next_slot`=1, `score_count` stays 512.
  - Slot 0 reads back 512; `high_score`=512.
- **Clear timing:** request clear with 3 stored scores.
  - `ram_we` high for exactly 512 consecutive cycles over addresses 0..511.
  - `clr_done` arrives at cycle 513.
  - `high_score`, `score_count` and `next_slot` are 0; reading slot 0 returns 0.
- **Reset mid-operation:** assert `reset` low during CLEAR at address 100 → all outputs 0 immediately; after release, FSM is IDLE and a new write lands at slot 0.
